bmem_arbiter: RTL and testbench
===============================

// Module: bmem_arbiter
// PURPOSE
//  Shares the single burst memory port (bmem_*) between NUM_REQ cacheline requesters (I-cache at
//  index 0, D-cache at index 1) and replaces the single-client adapter at the cpu top level.
//  Each requester issues one full-line read or write. The block grants requests round-robin and
//  runs a single transaction at a time. It splits/assembles 256-bit lines into 64-bit bursts and
//  returns a one-cycle resp to the owner.
// PARAMETERS
//  NUM_REQ    2    number of cacheline requesters
//  LINE_BITS  256  cacheline width
//  BEAT_BITS  64   bmem data beat width; BEATS = LINE_BITS/BEAT_BITS = 4
// PORTS
//  clk         in   1                   clock; all state on rising edge
//  rst_n       in   1                   reset, asynchronous, active-low
//  req_addr    in   NUM_REQ x 32        line address per requester (low 5 bits ignored)
//  req_read    in   NUM_REQ             read request (level; held until resp)
//  req_write   in   NUM_REQ             write request (level; held until resp)
//  req_wdata   in   NUM_REQ x LINE_BITS write line per requester
//  req_rdata   out  LINE_BITS           assembled read line, broadcast, valid with req_resp
//  req_resp    out  NUM_REQ             one-hot one-cycle completion pulse to owner
//  bmem_addr   out  32                  line-aligned address {addr[31:5],5'b0}
//  bmem_read   out  1                   read command (single cycle, accepted when bmem_ready)
//  bmem_write  out  1                   write beat valid (accepted when bmem_ready)
//  bmem_wdata  out  64                  write beat data
//  bmem_ready  in   1                   memory accepts command/beat this cycle
//  bmem_raddr  in   32                  address tag of returning read beat
//  bmem_rdata  in   64                  read beat data
//  bmem_rvalid in   1                   read beat valid
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; rr pointer = 0; beat counter = 0; line buffer = 0.
//  Requesters: read & write both high from the same requester is illegal (assert).
//    A requester with read|write high is pending.
//  States: IDLE -> RD_CMD -> RD_DATA -> RESP -> IDLE;  IDLE -> WR_DATA -> RESP -> IDLE.
//  IDLE: pick the first pending index at or after the rr pointer (wrapping).
//    Latch owner, op, aligned address and (for writes) the wdata line.
//    Set rr pointer = owner+1 mod NUM_REQ. No pending requester -> stay IDLE.
//    Latency: pending in cycle N -> bmem_read/bmem_write high in cycle N+1.
//  RD_CMD: bmem_read=1, bmem_addr=latched. Hold until bmem_ready; then go to RD_DATA.
//    bmem_read drops the following cycle.
//  RD_DATA: each rvalid with bmem_raddr == latched address stores rdata into beat slot cnt.
//    Beat 0 -> bits[63:0]; cnt increments. A mismatched-tag rvalid is ignored (assert).
//    After beat 3, go to RESP.
//  WR_DATA: bmem_write=1, bmem_addr=latched, bmem_wdata=latched_line[cnt*64 +: 64].
//    cnt advances only when bmem_ready=1, so beats may stall arbitrarily.
//    After beat 3 is accepted, go to RESP.
//  RESP: req_resp[owner]=1 for exactly one cycle. req_rdata holds the read line
//    (unspecified for writes). Then go to IDLE; the next grant may be evaluated in that
//    IDLE cycle, so back-to-back transactions are spaced by exactly one idle cycle.
//  Owner deasserting its request mid-transaction: the transaction still completes and resp still
//    pulses; memory beats are never abandoned.
//    Consequence: a pipeline flush does not cancel an in-flight I-cache fill.
//  rvalid outside RD_DATA is ignored. req_* changes of non-owners while busy have no effect.
//  Simultaneous pending after reset: index 0 wins, then alternation under continuous contention.
//    No requester waits longer than NUM_REQ-1 transactions.
//  rst_n asserted mid-burst: immediate return to reset values. Later rvalid beats are discarded
//    by the IDLE rule.
// STRUCTURE
//  cpu_params gets LINE_BITS, BEAT_BITS and BEATS.
//  rv32i_types gets typedef enum bmem_arb_state_t {IDLE, RD_CMD, RD_DATA, WR_DATA, RESP}.
//  One sub-module: rr_arbiter #(N) (pending vector + pointer -> one-hot grant). The FSM, beat
//    counter and line buffers stay in bmem_arbiter.
// TESTING
//  1. Req0 read 0x0000_1234, memory returns beats A,B,C,D (tag 0x0000_1220):
//     bmem_addr=0x0000_1220; req_rdata={D,C,B,A}; req_resp=2'b01 for one cycle.
//  2. Req1 write 0x8000_0040, line {W3,W2,W1,W0}, bmem_ready low on beat 1 for 3 cycles:
//     beats W0..W3 in order; W1 held 3 cycles; req_resp=2'b10 once.
//  3. Both requesters read continuously for 4 transactions:
//     grant order 0,1,0,1; resp pulses alternate; one idle cycle between bursts.
//  4. Req0 deasserts read right after the command is accepted:
//     4 beats are still consumed; req_resp[0] pulses; the arbiter then serves req1.
//  5. rvalid with wrong raddr during RD_DATA, plus stray rvalid in IDLE:
//     data is not captured; cnt is unchanged; the final line is correct.
//  6. rst_n low after beat 2 of a write, then release:
//     outputs 0 immediately; the next request starts from beat 0 with rr pointer 0.

Source files
------------

// File: rtl/bmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bmem_arbiter_pkg
// Purpose : Shared sizing constants, FSM state type and the line-alignment
//           helper for the burst-memory arbiter.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package bmem_arbiter_pkg;

  localparam int BMEM_NUM_REQ   = 2;
  localparam int BMEM_LINE_BITS = 256;
  localparam int BMEM_BEAT_BITS = 64;
  localparam int BMEM_BEATS     = BMEM_LINE_BITS / BMEM_BEAT_BITS;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_CMD  = 3'd1,
    RD_DATA = 3'd2,
    WR_DATA = 3'd3,
    RESP    = 3'd4
  } bmem_arb_state_t;

  // A 256-bit line spans 32 bytes, so the low 5 address bits are dropped.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFE0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bmem_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Purpose : Round-robin grant: picks the first pending index at or after the
//           pointer, wrapping around.
// Ports   : pending   - request vector (N)
//           ptr       - index with highest priority this evaluation
//           grant     - one-hot grant (N)
//           grant_idx - binary index of the granted requester
//           any       - at least one requester pending
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     pending,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any
);

  int               w_sum;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    w_sum     = 0;
    w_idx     = '0;
    for (int off = 0; off < N; off++) begin
      w_sum = int'(ptr) + off;
      if (w_sum >= N) w_sum = w_sum - N;
      w_idx = PTR_W'(w_sum);
      if (!any && pending[w_idx]) begin
        any          = 1'b1;
        grant[w_idx] = 1'b1;
        grant_idx    = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : bmem_arbiter
// Purpose : Shares one burst memory port between NUM_REQ cacheline clients.
//           One full-line transaction at a time, granted round-robin; lines
//           are split into / assembled from BEAT_BITS-wide beats.
// Ports   : clk, rst_n                    - clock, async active-low reset
//           req_addr/read/write/wdata     - per-requester line requests
//           req_rdata                     - read line, valid with req_resp
//           req_resp                      - one-hot completion pulse
//           bmem_addr/read/write/wdata    - memory command and write beats
//           bmem_ready                    - memory accepts command/beat
//           bmem_raddr/rdata/rvalid       - returning read beats
// Revision: 1.0 - initial release
// ============================================================================
module bmem_arbiter
  import bmem_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = BMEM_NUM_REQ,
  parameter int LINE_BITS = BMEM_LINE_BITS,
  parameter int BEAT_BITS = BMEM_BEAT_BITS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ*32-1:0]        req_addr,
  input  logic [NUM_REQ-1:0]           req_read,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*LINE_BITS-1:0] req_wdata,
  output logic [LINE_BITS-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]           req_resp,
  output logic [31:0]                  bmem_addr,
  output logic                         bmem_read,
  output logic                         bmem_write,
  output logic [BEAT_BITS-1:0]         bmem_wdata,
  input  logic                         bmem_ready,
  input  logic [31:0]                  bmem_raddr,
  input  logic [BEAT_BITS-1:0]         bmem_rdata,
  input  logic                         bmem_rvalid
);

  localparam int BEATS = LINE_BITS / BEAT_BITS;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  bmem_arb_state_t  r_state;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] r_owner;
  logic [CNT_W-1:0] r_cnt;

  logic [NUM_REQ-1:0]   w_pending;
  logic [NUM_REQ-1:0]   w_grant;
  logic [PTR_W-1:0]     w_gidx;
  logic                 w_any;
  logic [PTR_W-1:0]     w_next_ptr;
  logic [31:0]          w_sel_addr;
  logic                 w_sel_read;
  logic [LINE_BITS-1:0] w_sel_wdata;
  logic [CNT_W-1:0]     w_next_cnt;

  assign w_pending = req_read | req_write;

  rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .pending   (w_pending),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_gidx),
    .any       (w_any)
  );

  assign w_sel_addr  = req_addr[w_gidx*32 +: 32];
  assign w_sel_read  = |(req_read & w_grant);
  assign w_sel_wdata = req_wdata[w_gidx*LINE_BITS +: LINE_BITS];
  assign w_next_ptr  = (w_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
  assign w_next_cnt  = r_cnt + 1'b1;

  // req_rdata doubles as the line buffer: it collects read beats and holds
  // the outgoing line during writes (its content is don't-care for writes).
  // All req_* inputs are sampled only in IDLE, so requesters dropping or
  // changing their request mid-transaction cannot disturb a burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_cnt      <= '0;
      req_rdata  <= '0;
      req_resp   <= '0;
      bmem_addr  <= '0;
      bmem_read  <= 1'b0;
      bmem_write <= 1'b0;
      bmem_wdata <= '0;
    end else begin
      req_resp <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner   <= w_gidx;
            r_ptr     <= w_next_ptr;
            r_cnt     <= '0;
            bmem_addr <= line_align(w_sel_addr);
            if (w_sel_read) begin
              bmem_read <= 1'b1;
              r_state   <= RD_CMD;
            end else begin
              req_rdata  <= w_sel_wdata;
              bmem_wdata <= w_sel_wdata[BEAT_BITS-1:0];
              bmem_write <= 1'b1;
              r_state    <= WR_DATA;
            end
          end
        end
        RD_CMD: begin
          if (bmem_ready) begin
            bmem_read <= 1'b0;
            r_state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          // Beats tagged for another line are dropped without advancing.
          if (bmem_rvalid && (bmem_raddr == bmem_addr)) begin
            req_rdata[r_cnt*BEAT_BITS +: BEAT_BITS] <= bmem_rdata;
            r_cnt <= w_next_cnt;
            if (r_cnt == LAST_BEAT) begin
              req_resp[r_owner] <= 1'b1;
              r_state           <= RESP;
            end
          end
        end
        WR_DATA: begin
          if (bmem_ready) begin
            if (r_cnt == LAST_BEAT) begin
              bmem_write        <= 1'b0;
              r_cnt             <= '0;
              req_resp[r_owner] <= 1'b1;
              r_state           <= RESP;
            end else begin
              r_cnt      <= w_next_cnt;
              bmem_wdata <= req_rdata[w_next_cnt*BEAT_BITS +: BEAT_BITS];
            end
          end
        end
        RESP: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A requester may ask for a read or a write, never both at once.
  always_ff @(posedge clk) begin
    if (rst_n) assert ((req_read & req_write) == '0);
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_bmem_arbiter
// Purpose : Directed self-checking bench for bmem_arbiter: single read,
//           stalled write, contention, owner drop, tag filtering and reset.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_bmem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  req_addr;
  logic [1:0]   req_read;
  logic [1:0]   req_write;
  logic [511:0] req_wdata;
  logic [255:0] req_rdata;
  logic [1:0]   req_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bmem_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_addr    (req_addr),
    .req_read    (req_read),
    .req_write   (req_write),
    .req_wdata   (req_wdata),
    .req_rdata   (req_rdata),
    .req_resp    (req_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Returns four tagged read beats, one per cycle, lowest beat first.
  task automatic send_beats(input logic [31:0] tag, input logic [255:0] line);
    for (int i = 0; i < 4; i++) begin
      bmem_rvalid = 1'b1;
      bmem_raddr  = tag;
      bmem_rdata  = line[i*64 +: 64];
      step();
    end
    bmem_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] line;
    logic [255:0] wline;
    logic [31:0]  exp_addr;
    logic [1:0]   exp_resp;
    int           owner;

    rst_n       = 1'b0;
    req_addr    = '0;
    req_read    = '0;
    req_write   = '0;
    req_wdata   = '0;
    bmem_ready  = 1'b0;
    bmem_raddr  = '0;
    bmem_rdata  = '0;
    bmem_rvalid = 1'b0;
    #1;
    chk("rst_resp",  {254'd0, req_resp}, 256'd0);
    chk("rst_rdata", req_rdata, 256'd0);
    chk("rst_cmd",   {254'd0, bmem_read, bmem_write}, 256'd0);
    chk("rst_addr",  {224'd0, bmem_addr}, 256'd0);
    step(); step();
    rst_n      = 1'b1;
    bmem_ready = 1'b1;
    step();

    // 1: requester 0 reads 0x1234
    line = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003,
            64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
    req_addr[31:0] = 32'h0000_1234;
    req_read       = 2'b01;
    step();
    chk("t1_read",  {255'd0, bmem_read}, 256'd1);
    chk("t1_addr",  {224'd0, bmem_addr}, {224'd0, 32'h0000_1220});
    step();
    chk("t1_read_drop", {255'd0, bmem_read}, 256'd0);
    send_beats(32'h0000_1220, line);
    chk("t1_resp",  {254'd0, req_resp}, {254'd0, 2'b01});
    chk("t1_rdata", req_rdata, line);
    req_read = 2'b00;
    step();
    chk("t1_resp_once", {254'd0, req_resp}, 256'd0);

    // 2: requester 1 writes 0x8000_0040 with a 3-cycle stall on beat 1
    wline = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
             64'h1111_1111_1111_1111, 64'h0000_0000_0000_0F00};
    req_addr[63:32]    = 32'h8000_0040;
    req_wdata[511:256] = wline;
    req_write          = 2'b10;
    step();
    chk("t2_write", {255'd0, bmem_write}, 256'd1);
    chk("t2_addr",  {224'd0, bmem_addr}, {224'd0, 32'h8000_0040});
    chk("t2_w0",    {192'd0, bmem_wdata}, {192'd0, wline[63:0]});
    step();
    chk("t2_w1a", {192'd0, bmem_wdata}, {192'd0, wline[127:64]});
    bmem_ready = 1'b0;
    step();
    chk("t2_w1b", {192'd0, bmem_wdata}, {192'd0, wline[127:64]});
    step();
    chk("t2_w1c", {192'd0, bmem_wdata}, {192'd0, wline[127:64]});
    bmem_ready = 1'b1;
    step();
    chk("t2_w2", {192'd0, bmem_wdata}, {192'd0, wline[191:128]});
    step();
    chk("t2_w3", {192'd0, bmem_wdata}, {192'd0, wline[255:192]});
    step();
    chk("t2_resp",  {254'd0, req_resp}, {254'd0, 2'b10});
    chk("t2_wdrop", {255'd0, bmem_write}, 256'd0);
    req_write = 2'b00;
    step();
    chk("t2_resp_once", {254'd0, req_resp}, 256'd0);

    // 3: both requesters read continuously; expect 0,1,0,1
    req_addr[31:0]  = 32'h0000_1000;
    req_addr[63:32] = 32'h0000_2000;
    req_read        = 2'b11;
    for (int t = 0; t < 4; t++) begin
      owner    = t % 2;
      exp_addr = (owner == 1) ? 32'h0000_2000 : 32'h0000_1000;
      exp_resp = (owner == 1) ? 2'b10 : 2'b01;
      line     = {64'h3000_0000_0000_0003 | (64'(t) << 16), 64'h3000_0000_0000_0002 | (64'(t) << 16),
                  64'h3000_0000_0000_0001 | (64'(t) << 16), 64'h3000_0000_0000_0000 | (64'(t) << 16)};
      step();
      chk($sformatf("t3_read_%0d", t), {255'd0, bmem_read}, 256'd1);
      chk($sformatf("t3_addr_%0d", t), {224'd0, bmem_addr}, {224'd0, exp_addr});
      step();
      send_beats(exp_addr, line);
      chk($sformatf("t3_resp_%0d", t), {254'd0, req_resp}, {254'd0, exp_resp});
      chk($sformatf("t3_rdata_%0d", t), req_rdata, line);
      if (t == 3) req_read = 2'b00;
      step();
      chk($sformatf("t3_gap_%0d", t), {253'd0, bmem_read, req_resp}, 256'd0);
    end

    // 4: requester 0 drops its read right after command acceptance
    req_addr[31:0]  = 32'h0000_3000;
    req_addr[63:32] = 32'h0000_4000;
    req_read        = 2'b11;
    step();
    chk("t4_addr0", {224'd0, bmem_addr}, {224'd0, 32'h0000_3000});
    step();
    chk("t4_read_drop", {255'd0, bmem_read}, 256'd0);
    req_read = 2'b10;
    line = {64'h4444_0000_0000_0004, 64'h4444_0000_0000_0003,
            64'h4444_0000_0000_0002, 64'h4444_0000_0000_0001};
    send_beats(32'h0000_3000, line);
    chk("t4_resp0",  {254'd0, req_resp}, {254'd0, 2'b01});
    chk("t4_rdata0", req_rdata, line);
    step();
    step();
    chk("t4_read1", {255'd0, bmem_read}, 256'd1);
    chk("t4_addr1", {224'd0, bmem_addr}, {224'd0, 32'h0000_4000});
    step();
    line = {64'h5555_0000_0000_0004, 64'h5555_0000_0000_0003,
            64'h5555_0000_0000_0002, 64'h5555_0000_0000_0001};
    send_beats(32'h0000_4000, line);
    chk("t4_resp1",  {254'd0, req_resp}, {254'd0, 2'b10});
    chk("t4_rdata1", req_rdata, line);
    req_read = 2'b00;
    step();

    // 5: stray rvalid in IDLE and a wrong-tag beat mid-burst
    bmem_rvalid = 1'b1;
    bmem_raddr  = 32'h0000_5000;
    bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
    step();
    bmem_rvalid    = 1'b0;
    req_addr[31:0] = 32'h0000_5010;
    req_read       = 2'b01;
    step();
    chk("t5_addr", {224'd0, bmem_addr}, {224'd0, 32'h0000_5000});
    step();
    line = {64'h6666_0000_0000_0004, 64'h6666_0000_0000_0003,
            64'h6666_0000_0000_0002, 64'h6666_0000_0000_0001};
    bmem_rvalid = 1'b1;
    bmem_raddr = 32'h0000_5000; bmem_rdata = line[63:0];    step();
    bmem_raddr = 32'h0000_5020; bmem_rdata = 64'hBAD1;      step();
    bmem_raddr = 32'h0000_5000; bmem_rdata = line[127:64];  step();
    bmem_raddr = 32'h0000_5000; bmem_rdata = line[191:128]; step();
    chk("t5_no_early_resp", {254'd0, req_resp}, 256'd0);
    bmem_raddr = 32'h0000_5000; bmem_rdata = line[255:192]; step();
    bmem_rvalid = 1'b0;
    chk("t5_resp",  {254'd0, req_resp}, {254'd0, 2'b01});
    chk("t5_rdata", req_rdata, line);
    req_read = 2'b00;
    step();

    // 6: reset after beat 2 of a write, then contention restarts at index 0
    wline = {64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002,
             64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000};
    req_addr[31:0]   = 32'h0000_6000;
    req_wdata[255:0] = wline;
    req_write        = 2'b01;
    step();
    chk("t6_w0", {192'd0, bmem_wdata}, {192'd0, wline[63:0]});
    step(); step(); step();
    chk("t6_w3", {192'd0, bmem_wdata}, {192'd0, wline[255:192]});
    rst_n     = 1'b0;
    req_write = 2'b00;
    #1;
    chk("t6_rst_write", {255'd0, bmem_write}, 256'd0);
    chk("t6_rst_wdata", {192'd0, bmem_wdata}, 256'd0);
    chk("t6_rst_addr",  {224'd0, bmem_addr}, 256'd0);
    chk("t6_rst_rdata", req_rdata, 256'd0);
    step();
    rst_n = 1'b1;
    wline = {64'h8888_0000_0000_0003, 64'h8888_0000_0000_0002,
             64'h8888_0000_0000_0001, 64'h8888_0000_0000_0000};
    req_addr[31:0]   = 32'h0000_7000;
    req_wdata[255:0] = wline;
    req_addr[63:32]  = 32'h0000_9000;
    req_write        = 2'b01;
    req_read         = 2'b10;
    step();
    chk("t6_grant0", {254'd0, bmem_read, bmem_write}, 256'd1);
    chk("t6_addr",   {224'd0, bmem_addr}, {224'd0, 32'h0000_7000});
    chk("t6_u0",     {192'd0, bmem_wdata}, {192'd0, wline[63:0]});
    step();
    chk("t6_u1", {192'd0, bmem_wdata}, {192'd0, wline[127:64]});
    step(); step(); step();
    chk("t6_resp0", {254'd0, req_resp}, {254'd0, 2'b01});
    req_write = 2'b00;
    step();
    step();
    chk("t6_read1", {255'd0, bmem_read}, 256'd1);
    chk("t6_addr1", {224'd0, bmem_addr}, {224'd0, 32'h0000_9000});
    step();
    line = {64'h9999_0000_0000_0004, 64'h9999_0000_0000_0003,
            64'h9999_0000_0000_0002, 64'h9999_0000_0000_0001};
    send_beats(32'h0000_9000, line);
    chk("t6_resp1",  {254'd0, req_resp}, {254'd0, 2'b10});
    chk("t6_rdata1", req_rdata, line);
    req_read = 2'b00;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
